// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder
//   Pipelined adder: sum_o = (a_i + b_i + cin_i) mod 2^WIDTH, cout_o = carry out
//   of bit WIDTH-1. The operands are cut into STAGES segments of SEG bits. Each
//   rank adds one segment with a two-level carry-lookahead adder. Higher operand
//   segments travel forward in skew registers. Finished lower sums travel
//   forward in deskew registers, so the full sum is aligned at the last rank.
//   One global advance enable moves every rank together (valid/ready handshake).
//
// Parameters
//   WIDTH   operand/sum width, a multiple of STAGES*4
//   STAGES  number of register ranks (latency), 1..WIDTH/4
//   GROUP   lookahead group width, must divide WIDTH/STAGES
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   a_i/b_i/cin_i valid
//   in_ready_o   operands accepted this cycle (combinational advance enable)
//   a_i, b_i     operands
//   cin_i        carry-in
//   out_valid_o  sum_o/cout_o hold a valid result
//   out_ready_i  downstream consumes the result this cycle
//   sum_o        registered sum
//   cout_o       registered carry-out
//   ovf_o        registered signed overflow; exists only when the macro
//                PIPE_CLA_OVF_EN is defined
module pipe_cla_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef PIPE_CLA_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int SEG = WIDTH / STAGES;
    localparam int NG  = SEG / GROUP;

    // Two-level carry-lookahead add of one segment; returns {carry_out, sum}.
    // Level 1 forms group propagate/generate. Level 2 forms the carry into each
    // group from those terms. The bit sums inside a group are then formed from
    // the group carry.
    function automatic logic [SEG:0] cla_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           c_in);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] s;
        logic [NG:0]    gc;
        logic           gp;
        logic           gg;
        logic           c;
        p     = a ^ b;
        g     = a & b;
        s     = '0;
        gc    = '0;
        gc[0] = c_in;
        for (int j = 0; j < NG; j++) begin
            gp = 1'b1;
            gg = 1'b0;
            for (int i = 0; i < GROUP; i++) begin
                gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                gp = gp & p[j*GROUP+i];
            end
            gc[j+1] = gg | (gp & gc[j]);
        end
        for (int j = 0; j < NG; j++) begin
            c = gc[j];
            for (int i = 0; i < GROUP; i++) begin
                s[j*GROUP+i] = p[j*GROUP+i] ^ c;
                c            = g[j*GROUP+i] | (p[j*GROUP+i] & c);
            end
        end
        return {gc[NG], s};
    endfunction

    // A stalled output slot blocks the whole pipeline; otherwise every rank moves.
    logic en;
    assign en         = out_ready_i | ~out_valid_o;
    assign in_ready_o = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits that rank k has not added yet (its own segment plus the
        // segments above it).
        localparam int REM = WIDTH - k*SEG;

        logic [REM-1:0]       src_a;
        logic [REM-1:0]       src_b;
        logic                 src_c;
        logic                 src_v;
        logic [SEG:0]         seg_res;
        logic [(k+1)*SEG-1:0] next_sum;
        logic                 valid_q;
        logic                 carry_q;
        logic [(k+1)*SEG-1:0] sum_q;

        if (k == 0) begin : g_src
            assign src_a    = a_i;
            assign src_b    = b_i;
            assign src_c    = cin_i;
            assign src_v    = in_valid_i;
            assign next_sum = seg_res[SEG-1:0];
        end else begin : g_src
            assign src_a    = g_stage[k-1].g_reg.a_q;
            assign src_b    = g_stage[k-1].g_reg.b_q;
            assign src_c    = g_stage[k-1].carry_q;
            assign src_v    = g_stage[k-1].valid_q;
            assign next_sum = {seg_res[SEG-1:0], g_stage[k-1].sum_q};
        end

        assign seg_res = cla_add(src_a[SEG-1:0], src_b[SEG-1:0], src_c);

        if (k < STAGES-1) begin : g_reg
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] b_q;

            // NOTE: state registers use non-blocking assignments so that every
            // rank samples the old value of the rank before it on the same edge.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                end else if (en) begin
                    valid_q <= src_v;
                end
            end

            // NOTE: the datapath registers have no reset. Their contents only
            // matter when the matching valid bit is set, and the valid bits are reset.
            always_ff @(posedge clk_i) begin
                if (en) begin
                    carry_q <= seg_res[SEG];
                    sum_q   <= next_sum;
                    a_q     <= src_a[REM-1:SEG];
                    b_q     <= src_b[REM-1:SEG];
                end
            end
        end else begin : g_out
            // Output rank: the visible result changes only when a valid slot arrives.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                end else if (en) begin
                    valid_q <= src_v;
                    if (src_v) begin
                        carry_q <= seg_res[SEG];
                        sum_q   <= next_sum;
                    end
                end
            end

`ifdef PIPE_CLA_OVF_EN
            // The carry into the MSB equals a ^ b ^ sum at the MSB.
            logic ovf_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ovf_q <= 1'b0;
                end else if (en && src_v) begin
                    ovf_q <= seg_res[SEG] ^ src_a[SEG-1] ^ src_b[SEG-1] ^ seg_res[SEG-1];
                end
            end
`endif
        end
    end

    assign out_valid_o = g_stage[STAGES-1].valid_q;
    assign sum_o       = g_stage[STAGES-1].sum_q;
    assign cout_o      = g_stage[STAGES-1].carry_q;
`ifdef PIPE_CLA_OVF_EN
    assign ovf_o       = g_stage[STAGES-1].g_out.ovf_q;
`endif

endmodule
